// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer that sits beside
//                the execute stage. It performs a radix-2 shift-add multiply
//                or a restoring divide, one bit per cycle, and holds the
//                pipeline stalled until a single 32-bit result is presented.
//                Divide-by-zero and signed-overflow cases skip the loop.
//  Ports       : clk    - rising-edge clock
//                rst    - synchronous, active-low reset
//                start  - request, sampled only in IDLE
//                func3  - M-extension operation select
//                Read1  - rs1 operand (multiplicand / dividend)
//                Read2  - rs2 operand (multiplier / divisor)
//                flush  - abort the in-flight operation
//                result - result, valid while done=1, then held
//                done   - one-cycle result-valid pulse
//                busy   - operation in progress (CALC or DONE)
//                stall  - freeze PC and upstream pipeline registers
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] Read1,
   input  logic [XLEN-1:0] Read2,
   input  logic            flush,
   output logic [XLEN-1:0] result,
   output logic            done,
   output logic            busy,
   output logic            stall
);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_CALC = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;

   localparam logic [XLEN-1:0]   C_ZERO   = '0;
   localparam logic [XLEN-1:0]   C_ONES   = '1;
   localparam logic [XLEN-1:0]   C_ONE    = XLEN'(1);
   localparam logic [XLEN-1:0]   C_MIN    = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [2*XLEN-1:0] C_ONE_DW = (2*XLEN)'(1);
   localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(XLEN-1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;

   logic [2:0]        r_func3;
   logic              r_neg;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [2*XLEN-1:0] r_mcand;
   logic [XLEN-1:0]   r_mplier;
   logic [XLEN-1:0]   r_div;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_result;

   // ---------------------------------------------------------------
   // Operand conditioning at the accept edge
   // ---------------------------------------------------------------
   logic            w_a_signed, w_b_signed;
   logic            w_a_neg, w_b_neg, w_res_neg;
   logic [XLEN-1:0] w_a_abs, w_b_abs;
   logic            w_div0, w_ovf, w_fast;
   logic [XLEN-1:0] w_fast_val;
   logic            w_accept;

   // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: MUL, MULH, DIV, REM.
   assign w_a_signed = (func3 != 3'b011) & (~func3[2] | ~func3[0]);
   assign w_b_signed = func3[2] ? ~func3[0] : ~func3[1];
   assign w_a_neg    = w_a_signed & Read1[XLEN-1];
   assign w_b_neg    = w_b_signed & Read2[XLEN-1];
   assign w_a_abs    = w_a_neg ? (~Read1 + C_ONE) : Read1;
   assign w_b_abs    = w_b_neg ? (~Read2 + C_ONE) : Read2;

   // The remainder takes the dividend's sign; everything else the XOR.
   assign w_res_neg  = (func3[2] & func3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

   assign w_div0     = func3[2] & (Read2 == C_ZERO);
   assign w_ovf      = func3[2] & ~func3[0] & (Read1 == C_MIN) & (Read2 == C_ONES);
   assign w_fast     = w_div0 | w_ovf;

   always_comb begin
      w_fast_val = C_ZERO;
      if (w_div0)
         w_fast_val = func3[1] ? Read1 : C_ONES;
      else
         w_fast_val = func3[1] ? C_ZERO : C_MIN;
   end

   assign w_accept = (r_state == C_IDLE) & start & ~flush;

   // ---------------------------------------------------------------
   // One loop iteration (multiply and divide)
   // ---------------------------------------------------------------
   logic [2*XLEN-1:0] w_acc_nxt;
   logic [XLEN:0]     w_rem_sh, w_diff;
   logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt;
   logic [2*XLEN-1:0] w_mag, w_signed;
   logic [XLEN-1:0]   w_final;

   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {2*XLEN{1'b0}});

   // Restoring step: a borrow out of the subtraction means "keep old value".
   assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
   assign w_diff    = w_rem_sh - {1'b0, r_div};
   assign w_rem_nxt = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
   assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_diff[XLEN]};

   // A single 64-bit negator serves both paths; for divide results only
   // the low half is used, which equals a 32-bit two's complement.
   assign w_mag    = r_func3[2] ? {C_ZERO, (r_func3[1] ? w_rem_nxt : w_quo_nxt)} : w_acc_nxt;
   assign w_signed = r_neg ? (~w_mag + C_ONE_DW) : w_mag;
   assign w_final  = (r_func3[2] | (r_func3[1:0] == 2'b00)) ? w_signed[XLEN-1:0]
                                                            : w_signed[2*XLEN-1:XLEN];

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= C_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // FSM: next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_IDLE: begin
            if (start & ~flush)
               w_state_nxt = w_fast ? C_DONE : C_CALC;
         end
         C_CALC: begin
            if (flush)
               w_state_nxt = C_IDLE;
            else if (r_cnt == C_LAST)
               w_state_nxt = C_DONE;
         end
         C_DONE:  w_state_nxt = C_IDLE;
         default: w_state_nxt = C_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      done   = (r_state == C_DONE) & ~flush;
      busy   = (r_state != C_IDLE);
      stall  = (start & (r_state == C_IDLE)) | (busy & ~done);
      result = r_result;
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_func3  <= 3'b000;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_div    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_func3  <= func3;
         r_neg    <= w_res_neg;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {C_ZERO, w_a_abs};
         r_mplier <= w_b_abs;
         r_div    <= w_b_abs;
         r_rem    <= '0;
         r_quo    <= w_a_abs;
         if (w_fast)
            r_result <= w_fast_val;
      end else if ((r_state == C_CALC) && !flush) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_func3[2]) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
         end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
         end
         // Result is captured on the same edge that enters DONE.
         if (r_cnt == C_LAST)
            r_result <= w_final;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_seq
//  Description : Self-checking bench for ex_muldiv_seq. Directed cases plus
//                randomized operations compared with an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  func3 = 3'b000;
   logic [31:0] Read1 = '0;
   logic [31:0] Read2 = '0;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        stall;

   int checks = 0;
   int errors = 0;

   ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .func3  (func3),
      .Read1  (Read1),
      .Read2  (Read2),
      .flush  (flush),
      .result (result),
      .done   (done),
      .busy   (busy),
      .stall  (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: RV32M semantics from plain integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] up;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      ia = $signed(a);
      ib = $signed(b);
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   // One operation: one-cycle start, operands scrambled after accept,
   // bounded wait for done, then latency/result/stall/pulse checks.
   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int          cyc;
      logic        stall_ok;
      exp = model(f, a, b);
      @(negedge clk);
      func3 = f; Read1 = a; Read2 = b; start = 1'b1;
      #1;
      stall_ok = (stall === 1'b1);
      @(negedge clk);
      start = 1'b0;
      Read1 = $urandom;
      Read2 = $urandom;
      func3 = 3'($urandom_range(0, 7));
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
         if (stall !== 1'b1) stall_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      if (stall !== 1'b0) stall_ok = 1'b0;
      check({name, " latency"}, 64'(cyc), 64'(exp_lat(f, a, b)));
      check({name, " result"}, 64'(result), 64'(exp));
      check({name, " stall"}, 64'(stall_ok), 64'd1);
      @(negedge clk);
      check({name, " pulse/hold"}, {30'h0, done, busy, result}, {32'h0, exp});
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b, exp;
      int          cyc;
      logic        seen;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset outputs", {29'h0, done, busy, stall, result}, 64'h0);
      rst = 1'b1;

      // Directed arithmetic
      run_op("mul 7x6", 3'd0, 32'd7, 32'd6);
      run_op("mulh -1x-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhu -1x-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhsu -1x2", 3'd2, 32'hFFFF_FFFF, 32'd2);
      run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op("divu 100/7", 3'd5, 32'd100, 32'd7);
      run_op("remu 100/7", 3'd7, 32'd100, 32'd7);
      run_op("divu x/0", 3'd5, 32'h1234_0000, 32'd0);
      run_op("rem x/0", 3'd6, 32'h1234_5678, 32'd0);
      run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("mul min x min", 3'd0, 32'h8000_0000, 32'h8000_0000);

      // Randomized operations with boundary operands mixed in
      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       begin a = $urandom; b = $urandom; end
            1:       begin a = $urandom; b = 32'($urandom_range(0, 15)); end
            2:       begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd0; end
            default: begin a = $urandom | 32'h8000_0000; b = $urandom | 32'h8000_0000; end
         endcase
         run_op($sformatf("rand%0d f%0d", i, f), f, a, b);
      end

      // Flush at cycle 10 of a DIV
      @(negedge clk);
      func3 = 3'd4; Read1 = 32'd1000; Read2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush done low", {62'h0, done, busy}, 64'h1);
      @(negedge clk);
      flush = 1'b0;
      check("flush to idle", 64'(busy), 64'h0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check("flush no done", 64'(seen), 64'h0);
      run_op("mul 3x3 after flush", 3'd0, 32'd3, 32'd3);

      // Flush with start in IDLE: nothing accepted
      @(negedge clk);
      func3 = 3'd5; Read1 = 32'd9; Read2 = 32'd0; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush beats start", {62'h0, done, busy}, 64'h0);

      // Start held high: DONE-cycle start ignored, accepted on next IDLE
      a = $urandom; b = $urandom;
      exp = model(3'd3, a, b);
      @(negedge clk);
      func3 = 3'd3; Read1 = a; Read2 = b; start = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 40);
      check("held latency 1", 64'(cyc), 64'd33);
      check("held result 1", 64'(result), 64'(exp));
      @(negedge clk);
      check("held idle gap", {62'h0, busy, stall}, 64'h1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 40);
      check("held latency 2", 64'(cyc), 64'd33);
      check("held result 2", 64'(result), 64'(exp));
      start = 1'b0;

      // Reset at cycle 20 of a MUL with start held high
      @(negedge clk);
      func3 = 3'd0; Read1 = 32'd5; Read2 = 32'd9; start = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      rst = 1'b0;
      @(negedge clk);
      check("midop reset outputs", {30'h0, done, busy, result}, 64'h0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("midop reset no done", 64'(seen), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
